cu_fsm_seq: RTL and testbench
=============================

CU_FSM_SEQ -- requirements
Module: cu_fsm_seq

Interface
REQ-001 Parameter INTR_EN, default 1, SHALL gate interrupt support; when 0, pending interrupts are ignored.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 INTR  input  1  level-sensitive external interrupt request.
REQ-005 csr_mie  input  1  machine interrupt enable from the CSR file.
REQ-006 opcode  input  7  ir[6:0] of the current instruction.
REQ-007 func3  input  3  ir[14:12] of the current instruction.
REQ-008 pcWrite  output  1  PC register load enable.
REQ-009 regWrite  output  1  register file write enable.
REQ-010 memWE2  output  1  data memory write enable.
REQ-011 memRDEN1  output  1  instruction memory read enable.
REQ-012 memRDEN2  output  1  data memory read enable.
REQ-013 reset  output  1  PC/datapath reset pulse.
REQ-014 csr_WE  output  1  CSR file write enable.
REQ-015 int_taken  output  1  interrupt entry strobe to the CSR file and PC mux.
REQ-016 mret_exec  output  1  MRET strobe to the CSR file.

Function
REQ-017 The block SHALL be a 5-state FSM: INIT, FETCH, EXEC, WB, INTR.
REQ-018 Outputs SHALL be combinational from the current state and, in EXEC only, from opcode/func3; every output not listed for a state SHALL be 0.
REQ-019 INIT: reset=1; next state FETCH unconditionally.
REQ-020 FETCH: memRDEN1=1; next state EXEC.
REQ-021 EXEC, LOAD (0000011): memRDEN2=1, pcWrite=0, regWrite=0; next state WB.
REQ-022 EXEC, STORE (0100011): memWE2=1, pcWrite=1.
REQ-023 EXEC, BRANCH (1100011): pcWrite=1, regWrite=0.
REQ-024 EXEC, LUI/AUIPC/JAL/JALR/OP_IMM/OP (0110111, 0010111, 1101111, 1100111, 0010011, 0110011): pcWrite=1, regWrite=1.
REQ-025 EXEC, SYSTEM (1110011) with func3=001 (CSRRW): csr_WE=1, regWrite=1, pcWrite=1; with func3=000 (MRET): mret_exec=1, pcWrite=1; other func3: pcWrite=1 only.
REQ-026 EXEC, any other opcode: pcWrite=1 only (treated as NOP; no write strobes).
REQ-027 pending = INTR & csr_mie & INTR_EN, sampled in the cycle the FSM leaves EXEC (non-LOAD) or WB.
REQ-028 EXEC, non-LOAD: next state INTR if pending, else FETCH.
REQ-029 WB: regWrite=1, pcWrite=1; next state INTR if pending, else FETCH.
REQ-030 INTR: int_taken=1, pcWrite=1; next state FETCH unconditionally; INTR is not re-evaluated in this state.
REQ-031 Interrupts SHALL never be taken from INIT, FETCH or mid-LOAD (EXEC->WB); an instruction always completes before entry.
REQ-032 An MRET instruction with pending asserted in the same EXEC cycle SHALL assert mret_exec and then enter INTR.
REQ-033 At most one of memWE2, memRDEN2, int_taken, mret_exec, csr_WE SHALL be 1 in any cycle, except csr_WE with regWrite.
REQ-034 Unreachable state encodings SHALL transition to INIT.

Reset
REQ-035 RST=1 at a rising edge SHALL force state INIT regardless of current state, including mid-instruction; the next cycle shows reset=1 and all other outputs 0.
REQ-036 While RST is held, the FSM SHALL remain in INIT with reset=1.

Verification
REQ-037 RST 1 cycle then release, opcode=0010011 -> states INIT, FETCH, EXEC, FETCH; reset=1 cycle 1, memRDEN1=1 cycle 2, pcWrite=regWrite=1 cycle 3.
REQ-038 opcode=0000011 -> FETCH, EXEC (memRDEN2=1, pcWrite=0), WB (regWrite=pcWrite=1), FETCH.
REQ-039 opcode=0100011, INTR=1, csr_mie=1 -> EXEC memWE2=1, then INTR int_taken=1 pcWrite=1, then FETCH; repeat with csr_mie=0 -> no INTR state.
REQ-040 opcode=1110011 func3=001 -> csr_WE=regWrite=pcWrite=1 in EXEC; func3=000 -> mret_exec=1, regWrite=0.
REQ-041 LOAD with INTR rising during EXEC -> WB still occurs, INTR state follows WB.
REQ-042 RST asserted in WB -> next cycle INIT with regWrite=0, reset=1; INTR_EN=0 with INTR=csr_mie=1 -> int_taken never asserts.

Source files
------------

// File: rtl/cu_fsm_seq.sv
// Multicycle control unit: INIT/FETCH/EXEC/WB/INTR sequencer with Moore outputs
// plus opcode/func3 decode in EXEC. Interrupts enter only at instruction boundaries.
module cu_fsm_seq #(
  parameter int unsigned INTR_EN = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic       csr_mie,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  localparam logic INTR_ENABLED = (INTR_EN != 0);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  state_t state, next_state;
  logic   pending;

  assign pending = INTR & csr_mie & INTR_ENABLED;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = ST_INIT;
    pcWrite    = 1'b0;
    regWrite   = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    reset      = 1'b0;
    csr_WE     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;

    case (state)
      ST_INIT: begin
        reset      = 1'b1;
        next_state = ST_FETCH;
      end

      ST_FETCH: begin
        memRDEN1   = 1'b1;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        // Loads defer the PC update and the interrupt check to WB.
        next_state = pending ? ST_INTR : ST_FETCH;
        case (opcode)
          OPC_LOAD: begin
            memRDEN2   = 1'b1;
            next_state = ST_WB;
          end
          OPC_STORE: begin
            memWE2  = 1'b1;
            pcWrite = 1'b1;
          end
          OPC_BRANCH: begin
            pcWrite = 1'b1;
          end
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OPC_SYSTEM: begin
            pcWrite = 1'b1;
            if (func3 == F3_CSRRW) begin
              csr_WE   = 1'b1;
              regWrite = 1'b1;
            end else if (func3 == F3_MRET) begin
              mret_exec = 1'b1;
            end
          end
          default: begin
            pcWrite = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        regWrite   = 1'b1;
        pcWrite    = 1'b1;
        next_state = pending ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        int_taken  = 1'b1;
        pcWrite    = 1'b1;
        next_state = ST_FETCH;
      end

      default: begin
        next_state = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_cu_fsm_seq.sv
// Self-checking bench for cu_fsm_seq: per-instruction expected output sequences
// from an instruction-level model, compared cycle by cycle.
module tb_cu_fsm_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       INTR;
  logic       csr_mie;
  logic [6:0] opcode;
  logic [2:0] func3;

  logic pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec;
  logic pcWrite1, regWrite1, memWE21, memRDEN11, memRDEN21, reset1, csr_WE1, int_taken1, mret_exec1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  cu_fsm_seq #(.INTR_EN(1)) dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .csr_mie(csr_mie), .opcode(opcode), .func3(func3),
    .pcWrite(pcWrite), .regWrite(regWrite), .memWE2(memWE2), .memRDEN1(memRDEN1),
    .memRDEN2(memRDEN2), .reset(reset), .csr_WE(csr_WE), .int_taken(int_taken),
    .mret_exec(mret_exec)
  );

  cu_fsm_seq #(.INTR_EN(0)) dut_noint (
    .CLK(CLK), .RST(RST), .INTR(INTR), .csr_mie(csr_mie), .opcode(opcode), .func3(func3),
    .pcWrite(pcWrite1), .regWrite(regWrite1), .memWE2(memWE21), .memRDEN1(memRDEN11),
    .memRDEN2(memRDEN21), .reset(reset1), .csr_WE(csr_WE1), .int_taken(int_taken1),
    .mret_exec(mret_exec1)
  );

  // Vector order: pcWrite regWrite memWE2 memRDEN1 memRDEN2 reset csr_WE int_taken mret_exec
  logic [8:0] obs, obs1;
  assign obs  = {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec};
  assign obs1 = {pcWrite1, regWrite1, memWE21, memRDEN11, memRDEN21, reset1, csr_WE1, int_taken1, mret_exec1};

  localparam logic [8:0] V_INIT  = 9'b000001000;
  localparam logic [8:0] V_FETCH = 9'b000100000;
  localparam logic [8:0] V_WB    = 9'b110000000;
  localparam logic [8:0] V_INTR  = 9'b100000010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;

  logic [6:0] op_table [10] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011, 7'b1110011};

  // Expected EXEC-cycle outputs straight from the instruction class rules.
  function automatic logic [8:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'b0000011: return 9'b000010000;
      7'b0100011: return 9'b101000000;
      7'b1100011: return 9'b100000000;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011, 7'b0110011:
        return 9'b110000000;
      7'b1110011: begin
        if (f3 == 3'b001) return 9'b110000100;
        if (f3 == 3'b000) return 9'b100000001;
        return 9'b100000000;
      end
      default: return 9'b100000000;
    endcase
  endfunction

  // Whole-instruction output sequence starting at FETCH, with interrupt held for its duration.
  function automatic void instr_seq(input logic [6:0] op, input logic [2:0] f3, input bit pend,
                                    output logic [8:0] s [4], output int n);
    s = '{default: '0};
    s[0] = V_FETCH;
    s[1] = exec_vec(op, f3);
    n = 2;
    if (op == OP_LOAD) begin
      s[n] = V_WB;
      n = n + 1;
    end
    if (pend) begin
      s[n] = V_INTR;
      n = n + 1;
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves both DUTs in FETCH.
  task automatic apply_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1; INTR = 1'b0; csr_mie = 1'b0; opcode = OP_OPIMM; func3 = 3'b000;
    step();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (obs !== V_INIT) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", c, obs, V_INIT);
      end
      step();
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_op_imm();
    logic [8:0] s [4];
    int n;
    apply_reset();
    opcode = OP_OPIMM; func3 = 3'b101; INTR = 1'b0; csr_mie = 1'b1;
    instr_seq(opcode, func3, 1'b0, s, n);
    for (int c = 0; c < n; c++) begin
      n_checks++;
      if (obs !== s[c]) begin
        n_fail++;
        $display("FAIL op_imm cycle %0d: got %b expected %b", c, obs, s[c]);
      end
      step();
    end
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL op_imm_return: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_load();
    logic [8:0] s [4];
    int n;
    opcode = OP_LOAD; func3 = 3'b010; INTR = 1'b0; csr_mie = 1'b0;
    instr_seq(opcode, func3, 1'b0, s, n);
    for (int c = 0; c < n; c++) begin
      n_checks++;
      if (obs !== s[c]) begin
        n_fail++;
        $display("FAIL load cycle %0d: got %b expected %b", c, obs, s[c]);
      end
      step();
    end
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL load_return: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_store_intr();
    logic [8:0] s [4];
    int n;
    for (int k = 0; k < 2; k++) begin
      opcode = OP_STORE; func3 = 3'b010; INTR = 1'b1; csr_mie = (k == 0);
      instr_seq(opcode, func3, (k == 0), s, n);
      for (int c = 0; c < n; c++) begin
        n_checks++;
        if (obs !== s[c]) begin
          n_fail++;
          $display("FAIL store_intr mie=%0d cycle %0d: got %b expected %b", csr_mie, c, obs, s[c]);
        end
        step();
      end
    end
    INTR = 1'b0;
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL store_intr_return: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_system();
    logic [8:0] s [4];
    int n;
    logic [2:0] f3s [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
    for (int k = 0; k < 4; k++) begin
      opcode = OP_SYSTEM; func3 = f3s[k];
      INTR = (k == 3); csr_mie = 1'b1;   // last case: MRET with interrupt pending
      instr_seq(opcode, func3, (k == 3), s, n);
      for (int c = 0; c < n; c++) begin
        n_checks++;
        if (obs !== s[c]) begin
          n_fail++;
          $display("FAIL system f3=%b cycle %0d: got %b expected %b", func3, c, obs, s[c]);
        end
        step();
      end
    end
    INTR = 1'b0;
  endtask

  task automatic test_load_intr();
    // Interrupt rises during EXEC of a load and stays: WB first, then INTR.
    opcode = OP_LOAD; func3 = 3'b000; INTR = 1'b0; csr_mie = 1'b1;
    step();
    INTR = 1'b1;
    n_checks++;
    if (obs !== exec_vec(OP_LOAD, 3'b000)) begin
      n_fail++;
      $display("FAIL load_intr_exec: got %b expected %b", obs, exec_vec(OP_LOAD, 3'b000));
    end
    step();
    n_checks++;
    if (obs !== V_WB) begin
      n_fail++;
      $display("FAIL load_intr_wb: got %b expected %b", obs, V_WB);
    end
    step();
    n_checks++;
    if (obs !== V_INTR) begin
      n_fail++;
      $display("FAIL load_intr_entry: got %b expected %b", obs, V_INTR);
    end
    step();
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL load_intr_fetch: got %b expected %b", obs, V_FETCH);
    end
    // Interrupt present only during EXEC of a load: not taken.
    INTR = 1'b0;
    step();
    INTR = 1'b1;
    step();
    INTR = 1'b0;
    n_checks++;
    if (obs !== V_WB) begin
      n_fail++;
      $display("FAIL load_pulse_wb: got %b expected %b", obs, V_WB);
    end
    step();
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL load_pulse_no_intr: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LOAD; INTR = 1'b1; csr_mie = 1'b1;
    step();
    step();
    n_checks++;
    if (obs !== V_WB) begin
      n_fail++;
      $display("FAIL reset_mid_wb: got %b expected %b", obs, V_WB);
    end
    RST = 1'b1;
    step();
    n_checks++;
    if (obs !== V_INIT) begin
      n_fail++;
      $display("FAIL reset_mid_from_wb: got %b expected %b", obs, V_INIT);
    end
    step();
    n_checks++;
    if (obs !== V_INIT) begin
      n_fail++;
      $display("FAIL reset_mid_held: got %b expected %b", obs, V_INIT);
    end
    RST = 1'b0;
    step();
    opcode = OP_STORE;
    step();
    RST = 1'b1;
    step();
    n_checks++;
    if (obs !== V_INIT) begin
      n_fail++;
      $display("FAIL reset_mid_from_exec: got %b expected %b", obs, V_INIT);
    end
    RST = 1'b0; INTR = 1'b0;
    step();
    n_checks++;
    if (obs !== V_FETCH) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %b expected %b", obs, V_FETCH);
    end
  endtask

  task automatic test_random();
    logic [8:0] s [4];
    int n;
    bit pend;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 5) == 0) opcode = 7'($urandom);
      else                           opcode = op_table[$urandom_range(0, 9)];
      func3   = 3'($urandom);
      INTR    = 1'($urandom);
      csr_mie = 1'($urandom);
      pend    = INTR & csr_mie;
      instr_seq(opcode, func3, pend, s, n);
      for (int c = 0; c < n; c++) begin
        n_checks++;
        if (obs !== s[c]) begin
          n_fail++;
          $display("FAIL random instr %0d op=%b f3=%b pend=%0d cycle %0d: got %b expected %b",
                   k, opcode, func3, pend, c, obs, s[c]);
        end
        step();
      end
    end
    INTR = 1'b0;
  endtask

  task automatic test_intr_disabled();
    logic [8:0] s [4];
    int n;
    apply_reset();
    INTR = 1'b1; csr_mie = 1'b1;
    for (int k = 0; k < 40; k++) begin
      opcode = op_table[$urandom_range(0, 9)];
      func3  = 3'($urandom);
      instr_seq(opcode, func3, 1'b0, s, n);
      for (int c = 0; c < n; c++) begin
        n_checks++;
        if (obs1 !== s[c]) begin
          n_fail++;
          $display("FAIL intr_disabled instr %0d op=%b cycle %0d: got %b expected %b",
                   k, opcode, c, obs1, s[c]);
        end
        step();
      end
    end
    INTR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_op_imm();
    test_load();
    test_store_intr();
    test_system();
    test_load_intr();
    test_reset_mid();
    test_random();
    test_intr_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
